// File: rtl/soc_system_clkgen.sv
// soc_system_clkgen
// Multi-channel clock / clock-enable generator running off a single reference
// clock. Each channel has a runtime-programmable divide ratio (D), high time
// (H) and phase delay (P). It drives a registered square wave (outclk) and a
// one-cycle enable (clk_en) on the first high cycle of every period. A small
// lock FSM restarts all channels together after reset or after any channel is
// reprogrammed, and raises `locked` once the restarted channels have run for
// LOCK_CYCLES reference cycles.
//
// Configuration handshake (valid/ready):
//   A write transfers on a rising refclk edge where cfg_valid && cfg_ready.
//   The source raises cfg_valid with stable cfg_chan/cfg_div/cfg_high/
//   cfg_phase and holds all of them until that edge; the block never drops
//   cfg_ready without completing a transfer it already offered. cfg_ready is
//   high only in LOCKED. A transfer to an existing channel updates that
//   channel and restarts every channel (LOCKED -> ALIGN). A transfer to a
//   channel index at or above NUM_CLOCKS is consumed with no other effect.
//
// dbg_state exposes the lock FSM state (0=ALIGN, 1=SETTLE, 2=LOCKED).
module soc_system_clkgen #(
  parameter int NUM_CLOCKS  = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int RESET_DIV   = 2,
  localparam int CH_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] clk_en,
  output logic                  locked,
  output logic [1:0]            dbg_state
);

  // Settle counter only has to reach LOCK_CYCLES-1.
  localparam int                SET_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [31:0]       NUM_CH32    = 32'(NUM_CLOCKS);
  localparam logic [CNT_W-1:0]  ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TWO         = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_ALIGN  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SET_W-1:0]   settle_q;
  logic [SET_W-1:0]   settle_d;

  logic               cfg_accept;
  logic               chan_valid;
  logic               chan_hit;

  // Per-channel programmed operands.
  logic [CNT_W-1:0]   div_q   [NUM_CLOCKS];
  logic [CNT_W-1:0]   high_q  [NUM_CLOCKS];
  logic [CNT_W-1:0]   phase_q [NUM_CLOCKS];

  // Operands after the D=0 / H=0 / H>=D fix-ups.
  logic [CNT_W-1:0]   d_eff   [NUM_CLOCKS];
  logic [CNT_W-1:0]   h_eff   [NUM_CLOCKS];

  // Running counters: p_q = remaining phase-delay cycles, k_q = position in
  // the period that the next edge will present on the outputs.
  logic [CNT_W-1:0]   p_q     [NUM_CLOCKS];
  logic [CNT_W-1:0]   k_q     [NUM_CLOCKS];
  logic [CNT_W-1:0]   p_d     [NUM_CLOCKS];
  logic [CNT_W-1:0]   k_d     [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] out_d;
  logic [NUM_CLOCKS-1:0] en_d;

  assign cfg_ready  = (state_q == ST_LOCKED);
  assign locked     = (state_q == ST_LOCKED);
  assign dbg_state  = state_q;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign chan_valid = (32'(cfg_chan) < NUM_CH32);
  assign chan_hit   = cfg_accept && chan_valid;

  // Lock FSM state and settle counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ALIGN;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Lock FSM next state: one ALIGN cycle, LOCK_CYCLES of SETTLE, then LOCKED
  // until a write to a real channel forces a fresh alignment.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_ALIGN: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_LOCKED: begin
        if (chan_hit) begin
          state_d = ST_ALIGN;
        end
      end
      default: begin
        state_d  = ST_ALIGN;
        settle_d = '0;
      end
    endcase
  end

  // Channel operand registers; reset restores the default divider on all
  // channels, an accepted write to a real channel replaces its D/H/P.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= CNT_W'(RESET_DIV);
        high_q[i]  <= CNT_W'(RESET_DIV / 2);
        phase_q[i] <= '0;
      end
    end else if (chan_hit) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_chan == CH_W'(i)) begin
          div_q[i]   <= cfg_div;
          high_q[i]  <= cfg_high;
          phase_q[i] <= cfg_phase;
        end
      end
    end
  end

  // Effective operands: D=0 acts as 1, H=0 acts as 1, and H is clamped to
  // D-1 whenever D>=2 so a divided output always has a low phase.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      d_eff[i] = (div_q[i] == '0) ? ONE : div_q[i];
      h_eff[i] = (high_q[i] == '0) ? ONE : high_q[i];
      if ((d_eff[i] >= TWO) && (h_eff[i] >= d_eff[i])) begin
        h_eff[i] = d_eff[i] - ONE;
      end
    end
  end

  // Channel next state. Leaving ALIGN restarts every channel from k=0 with
  // its phase delay loaded, so all channels share the same start cycle. An
  // accepted realigning write blanks the outputs for the ALIGN cycle.
  always_comb begin
    out_d = '0;
    en_d  = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      logic [CNT_W-1:0] p_in;
      logic [CNT_W-1:0] k_in;
      p_in   = (state_q == ST_ALIGN) ? phase_q[i] : p_q[i];
      k_in   = (state_q == ST_ALIGN) ? '0 : k_q[i];
      p_d[i] = p_in;
      k_d[i] = k_in;
      if (p_in != '0) begin
        p_d[i] = p_in - ONE;
      end else begin
        out_d[i] = (k_in < h_eff[i]);
        en_d[i]  = (k_in == '0);
        k_d[i]   = (k_in >= d_eff[i] - ONE) ? '0 : k_in + ONE;
      end
      if (chan_hit) begin
        out_d[i] = 1'b0;
        en_d[i]  = 1'b0;
      end
    end
  end

  // Channel counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        p_q[i] <= '0;
        k_q[i] <= '0;
      end
      outclk <= '0;
      clk_en <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        p_q[i] <= p_d[i];
        k_q[i] <= k_d[i];
      end
      outclk <= out_d;
      clk_en <= en_d;
    end
  end

endmodule

// File: tb/tb_soc_system_clkgen.sv
// Directed bench for soc_system_clkgen. Three channels are used so that a
// channel index at or above NUM_CLOCKS is representable on cfg_chan.
// Expected waveforms are hand-written period strings per channel
// ("11000" = high for two cycles, low for three), indexed by t, the number
// of cycles since the first SETTLE cycle.
`timescale 1ns/1ps
module tb_soc_system_clkgen;

  localparam int NCH   = 3;
  localparam int CNT_W = 16;
  localparam int LOCK  = 16;
  localparam int CH_W  = 2;

  // ---------------- clock / reset ----------------
  logic             refclk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic [NCH-1:0]   outclk;
  logic [NCH-1:0]   clk_en;
  logic             locked;
  logic [1:0]       dbg_state;

  always #5 refclk = ~refclk;

  soc_system_clkgen #(
    .NUM_CLOCKS (NCH),
    .CNT_W      (CNT_W),
    .LOCK_CYCLES(LOCK),
    .RESET_DIV  (2)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .clk_en   (clk_en),
    .locked   (locked),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  string      out_pat [NCH];
  string      en_pat  [NCH];
  int         dly     [NCH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic cfg_drive(input int ch, input int d, input int h, input int p);
    cfg_chan  = CH_W'(ch);
    cfg_div   = CNT_W'(d);
    cfg_high  = CNT_W'(h);
    cfg_phase = CNT_W'(p);
    cfg_valid = 1'b1;
  endtask

  // Hold the request until an edge where cfg_ready was high, then drop it.
  task automatic wait_accept(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      logic r;
      r = cfg_ready;
      tick();
      if (r) done = 1'b1;
    end
    cfg_valid = 1'b0;
    check_val({tag, " accepted"}, 32'(done), 32'(1));
  endtask

  task automatic set_chan(input int ch, input string o, input string e, input int d);
    out_pat[ch] = o;
    en_pat[ch]  = e;
    dly[ch]     = d;
  endtask

  function automatic logic pat_bit(input string s, input int t, input int d);
    if (t < d) return 1'b0;
    return s.getc((t - d) % s.len()) == 8'h31;
  endfunction

  // ALIGN cycle: everything low.
  task automatic check_align(input string tag);
    check_val({tag, " align"}, 32'({cfg_ready, locked, clk_en, outclk}), 32'(0));
  endtask

  // Compare {cfg_ready, locked, clk_en, outclk} for t = t0 .. t0+n-1.
  task automatic check_window(input string tag, input int t0, input int n);
    for (int t = t0; t < t0 + n; t++) begin
      logic [NCH-1:0] eo;
      logic [NCH-1:0] ee;
      logic           lk;
      for (int c = 0; c < NCH; c++) begin
        eo[c] = pat_bit(out_pat[c], t, dly[c]);
        ee[c] = pat_bit(en_pat[c], t, dly[c]);
      end
      lk = (t >= LOCK);
      exp_q.push_back({lk, lk, ee, eo});
    end
    for (int t = t0; t < t0 + n; t++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check_val($sformatf("%s t=%0d", tag, t),
                32'({cfg_ready, locked, clk_en, outclk}), 32'(e));
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_high  = '0;
    cfg_phase = '0;

    // 1: reset defaults, D=2 H=1 on every channel, locked after edge 17
    tick();
    tick();
    check_val("reset outputs", 32'({cfg_ready, locked, clk_en, outclk}), 32'(0));
    rst_n = 1'b1;
    check_align("s1");
    tick();
    for (int c = 0; c < NCH; c++) set_chan(c, "10", "10", 0);
    check_window("s1", 0, 24);

    // 2: chan1 D=5 H=2 P=0
    cfg_drive(1, 5, 2, 0);
    wait_accept("s2");
    check_align("s2");
    tick();
    set_chan(1, "11000", "10000", 0);
    check_window("s2", 0, 24);

    // 3: chan1 D=4 H=2 P=3, first rise 3 cycles after chan0
    cfg_drive(1, 4, 2, 3);
    wait_accept("s3");
    check_align("s3");
    tick();
    set_chan(1, "1100", "1000", 3);
    check_window("s3", 0, 24);

    // 4a: D=0 acts as bypass
    cfg_drive(1, 0, 3, 0);
    wait_accept("s4a");
    check_align("s4a");
    tick();
    set_chan(1, "1", "1", 0);
    check_window("s4a", 0, 18);

    // 4b: D=1 bypass
    cfg_drive(1, 1, 1, 0);
    wait_accept("s4b");
    check_align("s4b");
    tick();
    check_window("s4b", 0, 18);

    // 4c: D=4 H=0 -> 1000
    cfg_drive(1, 4, 0, 0);
    wait_accept("s4c");
    check_align("s4c");
    tick();
    set_chan(1, "1000", "1000", 0);
    check_window("s4c", 0, 18);

    // 4d: chan2 D=4 H=7 -> 1110
    cfg_drive(2, 4, 7, 0);
    wait_accept("s4d");
    check_align("s4d");
    tick();
    set_chan(2, "1110", "1000", 0);
    check_window("s4d", 0, 20);

    // 5: write to nonexistent channel 3 is consumed without realigning
    cfg_drive(3, 9, 9, 9);
    check_window("s5 handshake", 20, 1);
    cfg_valid = 1'b0;
    check_window("s5 after", 21, 12);

    // 6a: request held through SETTLE is taken on the first LOCKED cycle
    cfg_drive(0, 3, 1, 0);
    wait_accept("s6a");
    check_align("s6a");
    tick();
    set_chan(0, "100", "100", 0);
    cfg_drive(2, 2, 1, 1);
    check_window("s6a hold", 0, 17);
    cfg_valid = 1'b0;
    check_align("s6a held");
    tick();
    set_chan(2, "10", "10", 1);
    check_window("s6a held write", 0, 20);

    // 6b: asynchronous reset in the middle of SETTLE
    cfg_drive(0, 2, 1, 0);
    wait_accept("s6b");
    check_align("s6b");
    tick();
    set_chan(0, "10", "10", 0);
    check_window("s6b settle", 0, 6);
    check_val("s6b pre-reset", 32'({clk_en, outclk}), 32'(6'b001001));
    #3;
    rst_n = 1'b0;
    #1;
    check_val("s6b async reset", 32'({cfg_ready, locked, clk_en, outclk}), 32'(0));
    tick();
    check_val("s6b in reset 1", 32'({cfg_ready, locked, clk_en, outclk}), 32'(0));
    tick();
    check_val("s6b in reset 2", 32'({cfg_ready, locked, clk_en, outclk}), 32'(0));
    rst_n = 1'b1;
    check_align("s6b release");
    tick();
    for (int c = 0; c < NCH; c++) set_chan(c, "10", "10", 0);
    check_window("s6b defaults", 0, 24);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
